wb_stage: RTL
=============

Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback-select stage of the 5-stage MIPS core (nocache SRAM variant).
- Captures M-stage results and extracts load data returned by the synchronous data SRAM one cycle after M.
- Drives the register file write port (we3/wa3/wd3; file writes on negedge clk) and the forwarding and debug trace outputs.

Parameters:
- PC_RESET, 32'hBFC0_0000, reset value of debug_wb_pc

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- stall_w  in  1  hold W-stage contents this cycle
- flush_w  in  1  squash instruction entering W (bubble)
- m_valid  in  1  M-stage instruction valid
- m_pc  in  32  M-stage PC
- m_regwrite  in  1  instruction writes a GPR
- m_memtoreg  in  1  writeback data comes from memory
- m_load_type  in  3  0=LW 1=LB 2=LBU 3=LH 4=LHU (5-7 treated as LW)
- m_wa  in  5  destination register
- m_alu_result  in  32  ALU result / load address
- data_sram_rdata  in  32  SRAM read data, valid in first W cycle
- we3  out  1  register file write enable
- wa3  out  5  register file write address
- wd3  out  32  register file write data
- w_fwd_valid  out  1  W holds a valid GPR-writing instruction
- w_fwd_wa  out  5  forwarding destination
- w_fwd_data  out  32  forwarding data (equals wd3)
- debug_wb_pc  out  32  retiring PC
- debug_wb_rf_wen  out  4  byte write enables for trace
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data
- retire_cnt  out  32  count of retired instructions

Behaviour:
- Registers w_valid, w_pc, w_regwrite, w_memtoreg, w_load_type, w_wa, w_alu are updated on posedge clk.
- rst=1 (highest priority): all W registers clear to 0, w_pc=PC_RESET, retire_cnt=0, rdata hold register=0, hold flag=0.
  - Resulting outputs: we3=0, wa3=0, wd3=0, w_fwd_valid=0, w_fwd_wa=0, w_fwd_data=0, debug_wb_pc=PC_RESET, debug_wb_rf_wen=0, debug_wb_rf_wnum=0, debug_wb_rf_wdata=0, retire_cnt=0.
- Register update, in priority order:
  - stall_w=1: hold everything; flush_w is ignored.
  - else flush_w=1: w_valid<=0; other fields don't care, but zeroing them is required.
  - else: load all M fields into W.
- Rdata hold register:
  - On the first W cycle of an instruction (hold flag=0) with stall_w=1: capture data_sram_rdata and set hold flag.
  - While hold flag=1: selected raw data = captured value. Otherwise raw data = data_sram_rdata.
  - Hold flag clears on any cycle with stall_w=0.
- Load extraction: off = w_alu[1:0], little-endian byte lane off.
  - LB/LBU: byte [8*off+7 : 8*off], sign-/zero-extended to 32 bits.
  - LH/LHU: halfword at off[1] (off[0] ignored; no alignment trap here), sign-/zero-extended.
  - LW: full word.
- wd3 = w_memtoreg ? extracted data : w_alu. wa3 = w_wa.
- we3 = w_valid & w_regwrite & ~stall_w & (w_wa!=0). Exactly one write per retiring instruction, in its final W cycle.
- w_fwd_valid = w_valid & w_regwrite & (w_wa!=0), regardless of stall. w_fwd_wa = w_wa; w_fwd_data = wd3.
- Debug trace:
  - debug_wb_pc = w_pc.
  - debug_wb_rf_wen = {4{we3}}.
  - debug_wb_rf_wnum = w_wa.
  - debug_wb_rf_wdata = wd3.
- retire_cnt increments by 1 at posedge when w_valid & ~stall_w; wraps 32'hFFFF_FFFF -> 0.
- Latency: M fields appear at W one cycle after posedge; write lands at the following negedge.
- Reset mid-stall: hold state is discarded; no write occurs in the reset cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with m_valid=1 -> we3=0, retire_cnt=0, debug_wb_pc=32'hBFC0_0000.
- ALU writeback: m_valid=1, regwrite=1, memtoreg=0, wa=5, alu=32'h1234_5678 -> next cycle we3=1, wa3=5, wd3=32'h1234_5678, retire_cnt=1.
- Loads, rdata=32'h80FF_7F01:
  - LB off=3 -> 32'hFFFF_FF80
  - LBU off=3 -> 32'h0000_0080
  - LH off=2 -> 32'hFFFF_80FF
  - LHU off=0 -> 32'h0000_7F01
  - LW -> 32'h80FF_7F01
- Stall with changing SRAM data: LW in W, stall_w=1 for 3 cycles while rdata changes 32'hAAAA_AAAA -> 32'h5555_5555 -> we3=0 during stall, w_fwd_data stays 32'hAAAA_AAAA; on release, single we3 pulse with 32'hAAAA_AAAA, retire_cnt +1 only.
- Flush and $0: flush_w=1 with valid M instruction -> W bubble (we3=0, w_fwd_valid=0, no count). Valid write to wa=0 -> we3=0, retire_cnt still increments.
- Stall has priority over flush: stall_w=1 and flush_w=1 together -> W contents unchanged, no write, no count.

Source files
------------

// File: rtl/wb_stage_if.sv
// Signal bundle between the M stage and the W stage. It also carries the
// register-file write port, the forwarding port and the debug trace port.
interface wb_stage_if;
  logic        stall_w;
  logic        flush_w;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_regwrite;
  logic        m_memtoreg;
  logic [2:0]  m_load_type;
  logic [4:0]  m_wa;
  logic [31:0] m_alu_result;
  logic [31:0] data_sram_rdata;

  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        w_fwd_valid;
  logic [4:0]  w_fwd_wa;
  logic [31:0] w_fwd_data;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] retire_cnt;

  modport slave (
    input  stall_w, flush_w, m_valid, m_pc, m_regwrite, m_memtoreg,
           m_load_type, m_wa, m_alu_result, data_sram_rdata,
    output we3, wa3, wd3, w_fwd_valid, w_fwd_wa, w_fwd_data, debug_wb_pc,
           debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, retire_cnt
  );

  modport master (
    output stall_w, flush_w, m_valid, m_pc, m_regwrite, m_memtoreg,
           m_load_type, m_wa, m_alu_result, data_sram_rdata,
    input  we3, wa3, wd3, w_fwd_valid, w_fwd_wa, w_fwd_data, debug_wb_pc,
           debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, retire_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback select. It extracts load data from
// the synchronous SRAM and drives the register-file write, forwarding and trace ports.
module wb_stage #(
  parameter logic [31:0] PC_RESET = 32'hBFC0_0000
) (
  input  logic     clk,
  input  logic     rst,
  wb_stage_if.slave bus
);

  logic        r_valid_p0;
  logic [31:0] r_pc_p0;
  logic        r_regwrite_p0;
  logic        r_memtoreg_p0;
  logic [2:0]  r_load_type_p0;
  logic [4:0]  r_wa_p0;
  logic [31:0] r_alu_p0;
  logic        r_hold_p0;
  logic [31:0] r_rdata_hold_p0;
  logic [31:0] r_retire_cnt;

  logic [31:0] w_raw;
  logic [31:0] w_wd;
  logic        w_wr_gpr;
  logic        w_we;

  function automatic logic [31:0] extract_load(input logic [2:0]  lt,
                                               input logic [1:0]  off,
                                               input logic [31:0] raw);
    logic signed [7:0]  v_b;
    logic signed [15:0] v_h;
    logic [31:0]        v_res;
    v_b = raw[{off, 3'b000} +: 8];
    v_h = off[1] ? raw[31:16] : raw[15:0];
    case (lt)
      3'd1:    v_res = 32'(v_b);
      3'd2:    v_res = {24'd0, v_b};
      3'd3:    v_res = 32'(v_h);
      3'd4:    v_res = {16'd0, v_h};
      default: v_res = raw;
    endcase
    return v_res;
  endfunction

  // M -> W pipeline register (stall outranks flush)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_p0     <= 1'b0;
      r_pc_p0        <= PC_RESET;
      r_regwrite_p0  <= 1'b0;
      r_memtoreg_p0  <= 1'b0;
      r_load_type_p0 <= 3'd0;
      r_wa_p0        <= 5'd0;
      r_alu_p0       <= 32'd0;
    end else if (bus.stall_w) begin
      r_valid_p0 <= r_valid_p0;
    end else if (bus.flush_w) begin
      r_valid_p0     <= 1'b0;
      r_pc_p0        <= 32'd0;
      r_regwrite_p0  <= 1'b0;
      r_memtoreg_p0  <= 1'b0;
      r_load_type_p0 <= 3'd0;
      r_wa_p0        <= 5'd0;
      r_alu_p0       <= 32'd0;
    end else begin
      r_valid_p0     <= bus.m_valid;
      r_pc_p0        <= bus.m_pc;
      r_regwrite_p0  <= bus.m_regwrite;
      r_memtoreg_p0  <= bus.m_memtoreg;
      r_load_type_p0 <= bus.m_load_type;
      r_wa_p0        <= bus.m_wa;
      r_alu_p0       <= bus.m_alu_result;
    end
  end

  // The SRAM only presents the load word in the first W cycle, so keep it while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_p0       <= 1'b0;
      r_rdata_hold_p0 <= 32'd0;
    end else if (!bus.stall_w) begin
      r_hold_p0 <= 1'b0;
    end else if (!r_hold_p0) begin
      r_hold_p0       <= 1'b1;
      r_rdata_hold_p0 <= bus.data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_retire_cnt <= 32'd0;
    else if (r_valid_p0 && !bus.stall_w)
      r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  // W stage: writeback select and output ports
  assign w_raw    = r_hold_p0 ? r_rdata_hold_p0 : bus.data_sram_rdata;
  assign w_wd     = r_memtoreg_p0 ? extract_load(r_load_type_p0, r_alu_p0[1:0], w_raw)
                                  : r_alu_p0;
  assign w_wr_gpr = r_valid_p0 & r_regwrite_p0 & (r_wa_p0 != 5'd0);
  assign w_we     = w_wr_gpr & ~bus.stall_w & ~rst;

  assign bus.we3               = w_we;
  assign bus.wa3               = r_wa_p0;
  assign bus.wd3               = w_wd;
  assign bus.w_fwd_valid       = w_wr_gpr;
  assign bus.w_fwd_wa          = r_wa_p0;
  assign bus.w_fwd_data        = w_wd;
  assign bus.debug_wb_pc       = r_pc_p0;
  assign bus.debug_wb_rf_wen   = {4{w_we}};
  assign bus.debug_wb_rf_wnum  = r_wa_p0;
  assign bus.debug_wb_rf_wdata = w_wd;
  assign bus.retire_cnt        = r_retire_cnt;

endmodule
